inst_mem_pipe: RTL and testbench
================================

Name: inst_mem_pipe

Overview:
Parametrised, clocked successor to the combinational instruction memory. It is a byte-addressed, big-endian instruction store with a program-load write port and a pipelined fetch port. The fetch port has a req/ready handshake, a configurable read latency, downstream stall, and alignment/range fault reporting. It sits between the PC/fetch stage and decode in the multi-cycle and pipelined processor variants.

Parameters:
DEPTH_BYTES, 256, store size in bytes; multiple of 4, at least 8.
READ_LAT, 1, fetch latency in cycles; legal values are 1 and 2 only.
FILL_WORD, 32'h00000000, word returned on faulted fetch (NOP).

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  synchronous, active-high reset.
fetch_req  in  1  fetch request.
fetch_addr  in  32  byte address of requested instruction.
fetch_ready  out  1  fetch port can accept this cycle.
stall  in  1  downstream hold; freezes the output and pipeline.
fetch_valid  out  1  fetch_inst, fetch_pc and fetch_fault are valid.
fetch_inst  out  32  {mem[a], mem[a+1], mem[a+2], mem[a+3]}, big-endian.
fetch_pc  out  32  address of the returned instruction.
fetch_fault  out  2  bit0 = misaligned, bit1 = out-of-range.
ld_en  in  1  program-load word write.
ld_addr  in  32  byte address of load word.
ld_data  in  32  load word; ld_data[31:24] goes to mem[ld_addr].
ld_err  out  1  one-cycle pulse: previous load dropped.
fault_cnt  out  8  saturating count of faulted fetches accepted.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: fetch_valid=0, fetch_inst=0, fetch_pc=0, fetch_fault=0, ld_err=0, fault_cnt=0. All in-flight fetches are discarded.
- Reset does not alter memory contents. Unloaded bytes are undefined; benches must load before fetching.
- fetch_ready = !rst && !ld_en && !stall, purely combinational.
- A fetch is accepted when fetch_req && fetch_ready. Memory is sampled in the accept cycle.
- Latency: accept in cycle N gives fetch_valid=1 in cycle N+READ_LAT. Throughput is one fetch per cycle.
- When no fetch is accepted, a bubble propagates: fetch_valid=0 with the data outputs held.
- Stall: while stall=1, every pipeline stage and output register holds, valid or not. fetch_valid is unchanged and no fetch is accepted. Release resumes with no loss or duplication.
- Faults are evaluated at accept on the full 32-bit address, with no wrap-around:
  - misaligned when fetch_addr[1:0] != 0;
  - out-of-range when fetch_addr > DEPTH_BYTES-4;
  - both bits may be set together.
- A faulted fetch still returns fetch_valid=1, fetch_inst=FILL_WORD, fetch_pc=fetch_addr. Memory is not read.
- fault_cnt increments at accept of a faulted fetch and saturates at 255.
- Load: when ld_en=1, the four bytes are written at the clock edge, in big-endian order.
  - If ld_addr is misaligned or > DEPTH_BYTES-4, the write is dropped and ld_err=1 in the next cycle only.
  - Loads are permitted while stall=1.
- A load and a fetch accept never coincide, because fetch_ready=0 whenever ld_en=1.
- A fetch accepted in the cycle after a load returns the newly loaded data.
- Reset mid-operation: the next cycle has fetch_valid=0 regardless of stall, and the pipeline is empty.
- READ_LAT values other than 1 or 2 are a configuration error, flagged by a simulation-time check.

Test Plan:
1. Load 0x3408000B at 0x0 and 0x34090008 at 0x4, then issue back-to-back fetches of 0x0 and 0x4 with READ_LAT=1. Required: valid in the cycles after each accept, with inst 0x3408000B/pc 0 followed by 0x34090008/pc 4, and fault=00 on both.
2. With DEPTH_BYTES=256, fetch 0xFC, 0x100, 0x2 and 0xFFFFFFFD. Required: fault 00, 10, 01 and 11 respectively. The faulted fetches return inst 0x00000000, and fault_cnt=3.
3. With READ_LAT=2, issue 3 consecutive fetches and assert stall for 2 cycles after the first valid output. Required: outputs and valid are held during the stall, and after release the remaining two words emerge in order with no duplicate or drop.
4. Hold ld_en=1 with fetch_req=1. Required: fetch_ready=0 and no valid output results. A load to 0x3 or 0x100 gives ld_err=1 for exactly one cycle and leaves memory unchanged on readback.
5. With READ_LAT=2, assert rst while two fetches are in flight. Required: fetch_valid=0 from the next cycle, fault_cnt=0, and previously loaded words still read back correctly after rst is released.
6. Drive 300 faulted fetches. Required: fault_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/inst_mem_pipe_if.sv
// rtl/inst_mem_pipe_if.sv - fetch and program-load bus of the pipelined instruction store
interface inst_mem_pipe_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        stall;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic [1:0]  fetch_fault;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_err;
  logic [7:0]  fault_cnt;

  // fetch/decode side drives requests and loads, reads results
  modport master (
    output fetch_req, fetch_addr, stall, ld_en, ld_addr, ld_data,
    input  fetch_ready, fetch_valid, fetch_inst, fetch_pc, fetch_fault, ld_err, fault_cnt
  );

  // the instruction store itself
  modport slave (
    input  fetch_req, fetch_addr, stall, ld_en, ld_addr, ld_data,
    output fetch_ready, fetch_valid, fetch_inst, fetch_pc, fetch_fault, ld_err, fault_cnt
  );
endinterface

// File: rtl/inst_mem_pipe.sv
// rtl/inst_mem_pipe.sv - byte-addressed big-endian instruction store with pipelined fetch port
module inst_mem_pipe #(
  parameter int          DEPTH_BYTES = 256,
  parameter int          READ_LAT    = 1,
  parameter logic [31:0] FILL_WORD   = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  inst_mem_pipe_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

  logic [7:0]    mem [DEPTH_BYTES];
  logic          accept;
  logic [1:0]    fault_now;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] ld_idx;
  logic [31:0]   rd_word;
  logic          ld_bad;

  logic          s1_valid;
  logic [31:0]   s1_inst;
  logic [31:0]   s1_pc;
  logic [1:0]    s1_fault;
  logic          ld_err_q;
  logic [7:0]    fault_cnt_q;

  // Loads own the array for their cycle, so fetches are refused while one is presented.
  assign bus.fetch_ready = !rst && !bus.ld_en && !bus.stall;
  assign accept          = bus.fetch_req && bus.fetch_ready;

  // Range test uses the full 32-bit address so high addresses never alias into the store.
  assign fault_now = {bus.fetch_addr > LAST_WORD, bus.fetch_addr[1:0] != 2'b00};
  assign ld_bad    = (bus.ld_addr[1:0] != 2'b00) || (bus.ld_addr > LAST_WORD);

  assign rd_idx  = bus.fetch_addr[AW-1:0];
  assign ld_idx  = bus.ld_addr[AW-1:0];
  assign rd_word = {mem[rd_idx], mem[rd_idx + AW'(1)], mem[rd_idx + AW'(2)], mem[rd_idx + AW'(3)]};

  // Program-load write, big-endian byte order; contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.ld_en && !ld_bad) begin
      mem[ld_idx]          <= bus.ld_data[31:24];
      mem[ld_idx + AW'(1)] <= bus.ld_data[23:16];
      mem[ld_idx + AW'(2)] <= bus.ld_data[15:8];
      mem[ld_idx + AW'(3)] <= bus.ld_data[7:0];
    end
  end

  // First fetch stage: sample memory (or fill word) at accept; stall freezes it, idle makes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inst  <= 32'h0;
      s1_pc    <= 32'h0;
      s1_fault <= 2'b00;
    end else if (!bus.stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_inst  <= (|fault_now) ? FILL_WORD : rd_word;
        s1_pc    <= bus.fetch_addr;
        s1_fault <= fault_now;
      end
    end
  end

  // Dropped-load pulse and saturating fault counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_err_q    <= 1'b0;
      fault_cnt_q <= 8'h00;
    end else begin
      ld_err_q <= bus.ld_en && ld_bad;
      if (accept && (|fault_now) && (fault_cnt_q != 8'hFF)) begin
        fault_cnt_q <= fault_cnt_q + 8'h01;
      end
    end
  end

  assign bus.ld_err    = ld_err_q;
  assign bus.fault_cnt = fault_cnt_q;

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        s2_valid;
      logic [31:0] s2_inst;
      logic [31:0] s2_pc;
      logic [1:0]  s2_fault;

      // Second stage: advances with the first, keeps its data across bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_inst  <= 32'h0;
          s2_pc    <= 32'h0;
          s2_fault <= 2'b00;
        end else if (!bus.stall) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_inst  <= s1_inst;
            s2_pc    <= s1_pc;
            s2_fault <= s1_fault;
          end
        end
      end

      assign bus.fetch_valid = s2_valid;
      assign bus.fetch_inst  = s2_inst;
      assign bus.fetch_pc    = s2_pc;
      assign bus.fetch_fault = s2_fault;
    end else begin : g_lat1
      assign bus.fetch_valid = s1_valid;
      assign bus.fetch_inst  = s1_inst;
      assign bus.fetch_pc    = s1_pc;
      assign bus.fetch_fault = s1_fault;
    end
  endgenerate

  // Only one- and two-cycle fetch latency are implemented.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (READ_LAT == 1 || READ_LAT == 2)
        else $error("inst_mem_pipe: READ_LAT=%0d is not 1 or 2", READ_LAT);
    end
  end
endmodule

// File: tb/tb_inst_mem_pipe.sv
// tb/tb_inst_mem_pipe.sv - directed self-checking bench for inst_mem_pipe at READ_LAT 1 and 2
module tb_inst_mem_pipe;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  inst_mem_pipe_if a_if ();
  inst_mem_pipe_if b_if ();

  inst_mem_pipe #(.DEPTH_BYTES(256), .READ_LAT(1), .FILL_WORD(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  inst_mem_pipe #(.DEPTH_BYTES(256), .READ_LAT(2), .FILL_WORD(32'h0000_0000)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic req, input logic [31:0] addr);
    a_if.fetch_req = req; a_if.fetch_addr = addr;
    b_if.fetch_req = req; b_if.fetch_addr = addr;
  endtask

  task automatic set_stall(input logic s);
    a_if.stall = s;
    b_if.stall = s;
  endtask

  task automatic set_ld(input logic en, input logic [31:0] addr, input logic [31:0] data);
    a_if.ld_en = en; a_if.ld_addr = addr; a_if.ld_data = data;
    b_if.ld_en = en; b_if.ld_addr = addr; b_if.ld_data = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_fetch(1'b0, 32'h0); set_stall(1'b0); set_ld(1'b0, 32'h0, 32'h0);
    tick(); tick();
    total++; if (a_if.fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", a_if.fetch_valid); end
    total++; if (a_if.fetch_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", a_if.fetch_inst); end
    total++; if (b_if.fetch_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", b_if.fetch_pc); end
    total++; if (a_if.fetch_fault !== 2'b00) begin bad++; $display("FAIL rst_fault got=%b exp=00", a_if.fetch_fault); end
    total++; if (a_if.ld_err !== 1'b0) begin bad++; $display("FAIL rst_ld_err got=%0b exp=0", a_if.ld_err); end
    total++; if (b_if.fault_cnt !== 8'd0) begin bad++; $display("FAIL rst_fault_cnt got=%0d exp=0", b_if.fault_cnt); end
    total++; if (a_if.fetch_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", a_if.fetch_ready); end
    rst = 1'b0;
    #1;
    total++; if (a_if.fetch_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0b exp=1", a_if.fetch_ready); end
  endtask

  task automatic test_load_fetch();
    set_ld(1'b1, 32'h0, 32'h3408_000B); tick();
    set_ld(1'b1, 32'h4, 32'h3409_0008); tick();
    total++; if (a_if.ld_err !== 1'b0) begin bad++; $display("FAIL good_ld_err got=%0b exp=0", a_if.ld_err); end
    set_ld(1'b0, 32'h0, 32'h0);
    set_fetch(1'b1, 32'h0); tick();
    total++; if (a_if.fetch_valid !== 1'b1 || a_if.fetch_inst !== 32'h3408_000B || a_if.fetch_pc !== 32'h0 || a_if.fetch_fault !== 2'b00)
      begin bad++; $display("FAIL lat1_first got=%0b/%h/%h/%b exp=1/3408000b/0/00", a_if.fetch_valid, a_if.fetch_inst, a_if.fetch_pc, a_if.fetch_fault); end
    total++; if (b_if.fetch_valid !== 1'b0) begin bad++; $display("FAIL lat2_early got=%0b exp=0", b_if.fetch_valid); end
    set_fetch(1'b1, 32'h4); tick();
    total++; if (a_if.fetch_valid !== 1'b1 || a_if.fetch_inst !== 32'h3409_0008 || a_if.fetch_pc !== 32'h4 || a_if.fetch_fault !== 2'b00)
      begin bad++; $display("FAIL lat1_second got=%0b/%h/%h/%b exp=1/34090008/4/00", a_if.fetch_valid, a_if.fetch_inst, a_if.fetch_pc, a_if.fetch_fault); end
    total++; if (b_if.fetch_valid !== 1'b1 || b_if.fetch_inst !== 32'h3408_000B || b_if.fetch_pc !== 32'h0)
      begin bad++; $display("FAIL lat2_first got=%0b/%h/%h exp=1/3408000b/0", b_if.fetch_valid, b_if.fetch_inst, b_if.fetch_pc); end
    set_fetch(1'b0, 32'h0); tick();
    total++; if (a_if.fetch_valid !== 1'b0 || a_if.fetch_inst !== 32'h3409_0008)
      begin bad++; $display("FAIL lat1_bubble got=%0b/%h exp=0/34090008", a_if.fetch_valid, a_if.fetch_inst); end
    total++; if (b_if.fetch_valid !== 1'b1 || b_if.fetch_inst !== 32'h3409_0008 || b_if.fetch_pc !== 32'h4)
      begin bad++; $display("FAIL lat2_second got=%0b/%h/%h exp=1/34090008/4", b_if.fetch_valid, b_if.fetch_inst, b_if.fetch_pc); end
    tick();
    total++; if (b_if.fetch_valid !== 1'b0 || b_if.fetch_pc !== 32'h4)
      begin bad++; $display("FAIL lat2_bubble got=%0b/%h exp=0/4", b_if.fetch_valid, b_if.fetch_pc); end
  endtask

  task automatic test_faults();
    set_ld(1'b1, 32'hFC, 32'hAABB_CCDD); tick();
    set_ld(1'b0, 32'h0, 32'h0);
    set_fetch(1'b1, 32'hFC); tick();
    total++; if (a_if.fetch_fault !== 2'b00 || a_if.fetch_inst !== 32'hAABB_CCDD || a_if.fetch_pc !== 32'hFC)
      begin bad++; $display("FAIL fault_fc got=%b/%h/%h exp=00/aabbccdd/fc", a_if.fetch_fault, a_if.fetch_inst, a_if.fetch_pc); end
    set_fetch(1'b1, 32'h100); tick();
    total++; if (a_if.fetch_valid !== 1'b1 || a_if.fetch_fault !== 2'b10 || a_if.fetch_inst !== 32'h0 || a_if.fetch_pc !== 32'h100)
      begin bad++; $display("FAIL fault_100 got=%0b/%b/%h/%h exp=1/10/0/100", a_if.fetch_valid, a_if.fetch_fault, a_if.fetch_inst, a_if.fetch_pc); end
    set_fetch(1'b1, 32'h2); tick();
    total++; if (a_if.fetch_fault !== 2'b01 || a_if.fetch_inst !== 32'h0 || a_if.fetch_pc !== 32'h2)
      begin bad++; $display("FAIL fault_2 got=%b/%h/%h exp=01/0/2", a_if.fetch_fault, a_if.fetch_inst, a_if.fetch_pc); end
    set_fetch(1'b1, 32'hFFFF_FFFD); tick();
    total++; if (a_if.fetch_fault !== 2'b11 || a_if.fetch_inst !== 32'h0 || a_if.fetch_pc !== 32'hFFFF_FFFD)
      begin bad++; $display("FAIL fault_fffffffd got=%b/%h/%h exp=11/0/fffffffd", a_if.fetch_fault, a_if.fetch_inst, a_if.fetch_pc); end
    set_fetch(1'b0, 32'h0); tick();
    total++; if (a_if.fault_cnt !== 8'd3) begin bad++; $display("FAIL fault_cnt_a got=%0d exp=3", a_if.fault_cnt); end
    total++; if (b_if.fault_cnt !== 8'd3 || b_if.fetch_fault !== 2'b11)
      begin bad++; $display("FAIL fault_cnt_b got=%0d/%b exp=3/11", b_if.fault_cnt, b_if.fetch_fault); end
    tick();
  endtask

  task automatic test_stall();
    set_ld(1'b1, 32'h8, 32'h1111_1111); tick();
    set_ld(1'b1, 32'hC, 32'h2222_2222); tick();
    set_ld(1'b1, 32'h10, 32'h3333_3333); tick();
    set_ld(1'b0, 32'h0, 32'h0);
    set_fetch(1'b1, 32'h8); tick();
    set_fetch(1'b1, 32'hC); tick();
    total++; if (b_if.fetch_valid !== 1'b1 || b_if.fetch_pc !== 32'h8 || b_if.fetch_inst !== 32'h1111_1111)
      begin bad++; $display("FAIL stall_first got=%0b/%h/%h exp=1/8/11111111", b_if.fetch_valid, b_if.fetch_pc, b_if.fetch_inst); end
    set_fetch(1'b1, 32'h10); set_stall(1'b1);
    #1;
    total++; if (b_if.fetch_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0b exp=0", b_if.fetch_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (b_if.fetch_valid !== 1'b1 || b_if.fetch_pc !== 32'h8 || b_if.fetch_inst !== 32'h1111_1111)
        begin bad++; $display("FAIL stall_hold_b%0d got=%0b/%h/%h exp=1/8/11111111", i, b_if.fetch_valid, b_if.fetch_pc, b_if.fetch_inst); end
      total++; if (a_if.fetch_valid !== 1'b1 || a_if.fetch_pc !== 32'hC)
        begin bad++; $display("FAIL stall_hold_a%0d got=%0b/%h exp=1/c", i, a_if.fetch_valid, a_if.fetch_pc); end
    end
    set_stall(1'b0); tick();
    total++; if (b_if.fetch_valid !== 1'b1 || b_if.fetch_pc !== 32'hC || b_if.fetch_inst !== 32'h2222_2222)
      begin bad++; $display("FAIL stall_second got=%0b/%h/%h exp=1/c/22222222", b_if.fetch_valid, b_if.fetch_pc, b_if.fetch_inst); end
    total++; if (a_if.fetch_valid !== 1'b1 || a_if.fetch_pc !== 32'h10)
      begin bad++; $display("FAIL stall_a_third got=%0b/%h exp=1/10", a_if.fetch_valid, a_if.fetch_pc); end
    set_fetch(1'b0, 32'h0); tick();
    total++; if (b_if.fetch_valid !== 1'b1 || b_if.fetch_pc !== 32'h10 || b_if.fetch_inst !== 32'h3333_3333)
      begin bad++; $display("FAIL stall_third got=%0b/%h/%h exp=1/10/33333333", b_if.fetch_valid, b_if.fetch_pc, b_if.fetch_inst); end
    tick();
    total++; if (b_if.fetch_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%0b exp=0", b_if.fetch_valid); end
  endtask

  task automatic test_load_err();
    set_fetch(1'b1, 32'h0);
    set_ld(1'b1, 32'h3, 32'hDEAD_BEEF);
    #1;
    total++; if (a_if.fetch_ready !== 1'b0) begin bad++; $display("FAIL ld_ready got=%0b exp=0", a_if.fetch_ready); end
    tick();
    total++; if (a_if.ld_err !== 1'b1 || a_if.fetch_valid !== 1'b0)
      begin bad++; $display("FAIL ld_err_mis got=%0b/%0b exp=1/0", a_if.ld_err, a_if.fetch_valid); end
    set_ld(1'b0, 32'h0, 32'h0); set_fetch(1'b0, 32'h0); tick();
    total++; if (a_if.ld_err !== 1'b0) begin bad++; $display("FAIL ld_err_pulse1 got=%0b exp=0", a_if.ld_err); end
    set_fetch(1'b1, 32'h4);
    set_ld(1'b1, 32'h100, 32'hDEAD_BEEF); tick();
    total++; if (b_if.ld_err !== 1'b1 || a_if.fetch_valid !== 1'b0)
      begin bad++; $display("FAIL ld_err_range got=%0b/%0b exp=1/0", b_if.ld_err, a_if.fetch_valid); end
    set_ld(1'b0, 32'h0, 32'h0); set_fetch(1'b0, 32'h0); tick();
    total++; if (b_if.ld_err !== 1'b0 || b_if.fetch_valid !== 1'b0)
      begin bad++; $display("FAIL ld_err_pulse2 got=%0b/%0b exp=0/0", b_if.ld_err, b_if.fetch_valid); end
    set_fetch(1'b1, 32'h0); tick();
    total++; if (a_if.fetch_inst !== 32'h3408_000B) begin bad++; $display("FAIL ld_keep0 got=%h exp=3408000b", a_if.fetch_inst); end
    set_fetch(1'b1, 32'hFC); tick();
    total++; if (a_if.fetch_inst !== 32'hAABB_CCDD) begin bad++; $display("FAIL ld_keepfc got=%h exp=aabbccdd", a_if.fetch_inst); end
    set_fetch(1'b0, 32'h0);
    set_ld(1'b1, 32'h20, 32'hCAFE_F00D); tick();
    set_ld(1'b0, 32'h0, 32'h0);
    set_fetch(1'b1, 32'h20); tick();
    total++; if (a_if.fetch_valid !== 1'b1 || a_if.fetch_inst !== 32'hCAFE_F00D)
      begin bad++; $display("FAIL ld_then_fetch got=%0b/%h exp=1/cafef00d", a_if.fetch_valid, a_if.fetch_inst); end
    set_fetch(1'b0, 32'h0); tick(); tick();
  endtask

  task automatic test_reset_mid();
    set_fetch(1'b1, 32'h0); tick();
    set_fetch(1'b1, 32'h4); tick();
    rst = 1'b1; set_stall(1'b1); tick();
    total++; if (b_if.fetch_valid !== 1'b0 || a_if.fetch_valid !== 1'b0)
      begin bad++; $display("FAIL rst_mid_valid got=%0b/%0b exp=0/0", b_if.fetch_valid, a_if.fetch_valid); end
    total++; if (b_if.fault_cnt !== 8'd0 || b_if.fetch_inst !== 32'h0)
      begin bad++; $display("FAIL rst_mid_cnt got=%0d/%h exp=0/0", b_if.fault_cnt, b_if.fetch_inst); end
    rst = 1'b0; set_stall(1'b0); set_fetch(1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (b_if.fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_empty%0d got=%0b exp=0", i, b_if.fetch_valid); end
    end
    set_fetch(1'b1, 32'h4); tick();
    set_fetch(1'b0, 32'h0); tick();
    total++; if (b_if.fetch_valid !== 1'b1 || b_if.fetch_inst !== 32'h3409_0008 || b_if.fetch_pc !== 32'h4)
      begin bad++; $display("FAIL rst_mid_readback got=%0b/%h/%h exp=1/34090008/4", b_if.fetch_valid, b_if.fetch_inst, b_if.fetch_pc); end
    tick();
  endtask

  task automatic test_saturate();
    set_fetch(1'b1, 32'h1);
    for (int i = 0; i < 254; i++) tick();
    total++; if (a_if.fault_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", a_if.fault_cnt); end
    tick();
    total++; if (a_if.fault_cnt !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", a_if.fault_cnt); end
    for (int i = 0; i < 45; i++) tick();
    total++; if (a_if.fault_cnt !== 8'd255 || b_if.fault_cnt !== 8'd255)
      begin bad++; $display("FAIL sat_hold got=%0d/%0d exp=255/255", a_if.fault_cnt, b_if.fault_cnt); end
    set_fetch(1'b0, 32'h0); tick();
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_faults();
    test_stall();
    test_load_err();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
